sprite_draw_engine: RTL and testbench



---
 rtl/draw_pkg.sv | 27 ++
 rtl/sprite_addr_gen.sv | 76 +++++++
 rtl/sprite_draw_engine.sv | 140 ++++++++++++++
 tb/tb_sprite_draw_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the sprite drawing blocks: FSM encoding, screen
// geometry, colour width, the transparent colour key and a clog2 helper.
package draw_pkg;

  // Draw FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Screen geometry and colour format of the VGA adapter
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;

  // ROM colour key that is never plotted
  localparam logic [COLOUR_W-1:0] TRANSPARENT = 3'b000;

  // Number of bits needed to index 'value' entries (minimum 0)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Column/row walker for one sprite: keeps the cx/cy counters, composes the
// row-major ROM address and flags the last pixel.
// Optional macro SPRITE_MIRROR_EN adds a mirror input that reverses the
// column used for the ROM address (the counters themselves are unchanged).
module sprite_addr_gen
  import draw_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  localparam int CXW = clog2(SPR_W),
  localparam int CYW = clog2(SPR_H),
  localparam int AW  = CXW + CYW
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           step,
`ifdef SPRITE_MIRROR_EN
  input  logic           mirror,
`endif
  output logic [AW-1:0]  addr,
  output logic [CXW-1:0] cx,
  output logic [CYW-1:0] cy,
  output logic           last
);

  localparam logic [CXW-1:0] CX_MAX = CXW'(SPR_W - 1);
  localparam logic [CYW-1:0] CY_MAX = CYW'(SPR_H - 1);

  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic [CXW-1:0] col;

  // Next counter values: clear wins, otherwise step along the row and wrap
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step) begin
      if (cx_q == CX_MAX) begin
        cx_d = '0;
        cy_d = cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  // Column used for the ROM lookup; mirroring reads the row right-to-left
  always_comb begin
`ifdef SPRITE_MIRROR_EN
    col = mirror ? (CX_MAX - cx_q) : cx_q;
`else
    col = cx_q;
`endif
  end

  assign addr = {cy_q, col};
  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == CX_MAX) && (cy_q == CY_MAX);

endmodule

// File: rtl/sprite_draw_engine.sv
// Responder end of the view-FSM draw handshake: streams one SPR_W x SPR_H
// sprite from a ROM into the VGA adapter at a latched position, one pixel
// per cycle, then reports done.
// Optional macro SPRITE_MIRROR_EN adds a 'mirror' input (sampled with
// x_pos) that flips the sprite horizontally.
//
// Handshake: enable is a level request. It is accepted in IDLE; busy is high
// while the sprite streams; done is a level held until enable falls, and the
// block returns to IDLE in the cycle after enable is seen low. Dropping enable
// before done aborts the draw without ever raising done.
module sprite_draw_engine
  import draw_pkg::*;
#(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int COLOUR_W = draw_pkg::COLOUR_W,
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = draw_pkg::TRANSPARENT,
  localparam int AW  = clog2(SPR_W * SPR_H),
  localparam int CXW = clog2(SPR_W),
  localparam int CYW = clog2(SPR_H)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [7:0]          x_pos,
  input  logic [6:0]          y_pos,
`ifdef SPRITE_MIRROR_EN
  input  logic                mirror,
`endif
  output logic [AW-1:0]       rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                done,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  logic [1:0]     state_q, state_d;
  logic [7:0]     x0_q;
  logic [6:0]     y0_q;
  logic           valid_q;
  logic [8:0]     px_q;
  logic [7:0]     py_q;
  logic           fetching;
  logic           gen_clear;
  logic [AW-1:0]  gen_addr;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic           last;
`ifdef SPRITE_MIRROR_EN
  logic           mirror_q;
`endif

  // A ROM read is issued only in FETCH while the request is still held
  assign fetching  = (state_q == ST_FETCH) && enable;
  assign gen_clear = (state_q != ST_FETCH);

  sprite_addr_gen #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_addr_gen (
    .clk    (clk),
    .resetn (resetn),
    .clear  (gen_clear),
    .step   (fetching),
`ifdef SPRITE_MIRROR_EN
    .mirror (mirror_q),
`endif
    .addr   (gen_addr),
    .cx     (cx),
    .cy     (cy),
    .last   (last)
  );

  // Next-state logic; losing enable anywhere before DONE aborts to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_FETCH;
      ST_FETCH: begin
        if (!enable)   state_d = ST_IDLE;
        else if (last) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = enable ? ST_DONE : ST_IDLE;
      ST_DONE:  if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and request latch (position sampled on accept only)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
`ifdef SPRITE_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && enable) begin
        x0_q     <= x_pos;
        y0_q     <= y_pos;
`ifdef SPRITE_MIRROR_EN
        mirror_q <= mirror;
`endif
      end
    end
  end

  // One-stage pipeline aligning screen coordinates with the ROM read latency;
  // widened sums keep off-screen pixels from wrapping back on screen
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      valid_q <= fetching;
      px_q    <= 9'(x0_q) + 9'(cx);
      py_q    <= 8'(y0_q) + 8'(cy);
    end
  end

  assign rom_addr   = (state_q == ST_FETCH) ? gen_addr : '0;
  assign vga_x      = px_q[7:0];
  assign vga_y      = py_q[6:0];
  assign vga_colour = valid_q ? rom_data : '0;
  assign vga_plot   = valid_q && (rom_data != TRANSPARENT) &&
                      (px_q < 9'(SCREEN_W)) && (py_q < 8'(SCREEN_H));
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine with a registered sprite ROM model
// and a pixel scoreboard. Build with SPRITE_MIRROR_EN to add the mirror case.
module tb_sprite_draw_engine;

  localparam int W = 18; // {x[7:0], y[6:0], colour[2:0]}

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       mirror_r;
  logic [7:0] rom_addr;
  logic [2:0] rom_data = 3'b000;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;
  logic       busy;
  logic [1:0] state_dbg;

  logic [2:0]   rom_mem [256];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] obs_mem [4096];
  int           obs_wr = 0;
  int           obs_rd = 0;
  int           chk_cnt = 0;
  int           err_cnt = 0;
  int           lat;

  sprite_draw_engine dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
`ifdef SPRITE_MIRROR_EN
    .mirror     (mirror_r),
`endif
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .done       (done),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Sprite ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Plot monitor: records every plotted pixel for the scoreboard
  always @(negedge clk) begin
    if (vga_plot === 1'b1 && obs_wr < 4096) begin
      obs_mem[obs_wr] = {vga_x, vga_y, vga_colour};
      obs_wr++;
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected plots for the first n addresses of a draw
  task automatic push_px(input int x0, input int y0, input logic mir, input int n);
    int cx, cy, src, px, py;
    logic [2:0] col;
    logic [7:0] pxb;
    logic [6:0] pyb;
    for (int a = 0; a < n; a++) begin
      cx  = a % 16;
      cy  = a / 16;
      src = mir ? (cy * 16 + (15 - cx)) : a;
      px  = x0 + cx;
      py  = y0 + cy;
      col = rom_mem[src];
      if (col != 3'b000 && px < 160 && py < 120) begin
        pxb = px[7:0];
        pyb = py[6:0];
        exp_q.push_back({pxb, pyb, col});
      end
    end
  endtask

  // Compare observed plots against the expected queue, then resync
  task automatic score(input string tag);
    logic [W-1:0] e;
    check({tag, "_plot_count"}, obs_wr - obs_rd, exp_q.size());
    while (obs_rd < obs_wr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_pixel"}, obs_mem[obs_rd], e);
      obs_rd++;
    end
    obs_rd = obs_wr;
    exp_q.delete();
  endtask

  task automatic start_req(input int x, input int y, input logic mir);
    @(negedge clk);
    x_pos    = x[7:0];
    y_pos    = y[6:0];
    mirror_r = mir;
    enable   = 1'b1;
  endtask

  // Count cycles from the accept edge until done; scramble the position inputs
  // once the request is latched
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("busy_after_accept", busy, 1);
        check("first_rom_addr", rom_addr, 0);
        x_pos = 8'($urandom_range(0, 255));
        y_pos = 7'($urandom_range(0, 127));
      end
    end while (!done && n < 1000);
  endtask

  task automatic release_req();
    enable = 1'b0;
    @(negedge clk);
    check("idle_after_release", state_dbg, 0);
    check("done_low_after_release", done, 0);
  endtask

  initial begin
    resetn   = 1'b0;
    enable   = 1'b0;
    x_pos    = '0;
    y_pos    = '0;
    mirror_r = 1'b0;
    for (int a = 0; a < 256; a++) rom_mem[a] = 3'b100;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rom_addr", rom_addr, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Solid sprite at (10,20), enable held past done
    push_px(10, 20, 1'b0, 256);
    start_req(10, 20, 1'b0);
    wait_done(lat);
    check("solid_latency", lat, 258);
    repeat (5) begin
      @(negedge clk);
      check("solid_done_held", done, 1);
      check("solid_busy_low", busy, 0);
    end
    release_req();
    score("solid");

    // Checkerboard with transparent even-parity pixels
    for (int a = 0; a < 256; a++)
      rom_mem[a] = (((a % 16) + (a / 16)) % 2 == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
    push_px(40, 30, 1'b0, 256);
    check("checker_model_count", exp_q.size(), 128);
    start_req(40, 30, 1'b0);
    wait_done(lat);
    check("checker_latency", lat, 258);
    release_req();
    score("checker");

    // Clipping at the bottom-right corner
    for (int a = 0; a < 256; a++) rom_mem[a] = 3'($urandom_range(1, 7));
    push_px(150, 110, 1'b0, 256);
    check("clip_model_count", exp_q.size(), 100);
    start_req(150, 110, 1'b0);
    wait_done(lat);
    check("clip_latency", lat, 258);
    check("clip_done", done, 1);
    release_req();
    score("clip");

    // Abort: enable dropped after 50 cycles; addresses 0..48 reach the screen
    for (int a = 0; a < 256; a++) rom_mem[a] = 3'b101;
    push_px(5, 7, 1'b0, 49);
    start_req(5, 7, 1'b0);
    repeat (50) @(negedge clk);
    enable = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("abort_plot_low", vga_plot, 0);
      check("abort_done_low", done, 0);
    end
    check("abort_state_idle", state_dbg, 0);
    score("abort");
    push_px(5, 7, 1'b0, 256);
    start_req(5, 7, 1'b0);
    wait_done(lat);
    check("after_abort_latency", lat, 258);
    release_req();
    score("after_abort");

    // Reset mid-draw with enable held: addresses 0..98 plotted before reset
    for (int a = 0; a < 256; a++) rom_mem[a] = 3'($urandom_range(1, 7));
    push_px(60, 50, 1'b0, 99);
    start_req(60, 50, 1'b0);
    repeat (100) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_plot", vga_plot, 0);
    check("midrst_vga_x", vga_x, 0);
    check("midrst_vga_y", vga_y, 0);
    check("midrst_colour", vga_colour, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_state", state_dbg, 0);
    score("midrst");
    push_px(60, 50, 1'b0, 256);
    resetn = 1'b1;
    wait_done(lat);
    check("restart_latency", lat, 258);
    release_req();
    score("restart");

`ifdef SPRITE_MIRROR_EN
    // Mirrored draw: (x0,y0) shows ROM[15], (x0+15,y0) shows ROM[0]
    for (int a = 0; a < 256; a++) rom_mem[a] = 3'($urandom_range(1, 7));
    push_px(20, 10, 1'b1, 256);
    check("mirror_first_px", exp_q[0], {8'd20, 7'd10, rom_mem[15]});
    start_req(20, 10, 1'b1);
    wait_done(lat);
    check("mirror_latency", lat, 258);
    release_req();
    score("mirror");
`endif

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
